// File: rtl/sram_frame_writer.sv
// Streams one frame of 16-bit pixels into async SRAM at word addresses 0..FRAME_WORDS-1.
// Each word takes 4 clocks (accept/setup/strobe/hold), and pix_ready_o is low for 3 of them.
module sram_frame_writer #(
  parameter int FRAME_WORDS = 1048576,
  parameter int ADDR_W      = 20
) (
  input  logic              clk108,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pix_valid_i,
  input  logic              pix_sof_i,
  input  logic [15:0]       pix_data_i,
  output logic              pix_ready_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [15:0]       sram_dq_out_o,
  output logic              sram_dq_oe_o,
  output logic              sram_we_n_o,
  output logic              sram_oe_n_o,
  output logic              disp_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_sof_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ACCEPT,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              pix_ready_q, pix_ready_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              disp_en_q, disp_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_sof_q, err_sof_d;

  logic hs;
  logic owns_sram_d;

  assign hs = pix_valid_i & pix_ready_q;

  // State register together with the registered outputs.
  always_ff @(posedge clk108 or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      pix_ready_q <= 1'b0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b0;
      disp_en_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pix_ready_q <= pix_ready_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      disp_en_q   <= disp_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_sof_q   <= err_sof_d;
    end
  end

  // Next state plus the address/data path. Address and data only move on entry to SETUP or DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_ARM;
      end
      S_ARM: begin
        if (hs && pix_sof_i) begin
          data_d  = pix_data_i;
          addr_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_ACCEPT: begin
        if (hs) begin
          data_d  = pix_data_i;
          addr_d  = pix_sof_i ? '0 : addr_q + ADDR_W'(1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_WRITE;
      S_WRITE: state_d = S_HOLD;
      S_HOLD: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        if (start_i) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they line up with the state once registered.
  always_comb begin
    owns_sram_d = (state_d != S_IDLE) && (state_d != S_DONE);
    pix_ready_d = (state_d == S_ARM) || (state_d == S_ACCEPT);
    dq_oe_d     = (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
    we_n_d      = (state_d != S_WRITE);
    oe_n_d      = owns_sram_d;
    disp_en_d   = !owns_sram_d;
    busy_d      = owns_sram_d;
    done_d      = (state_d == S_DONE) && (state_q != S_DONE);
    err_sof_d   = (state_q == S_ACCEPT) && hs && pix_sof_i;
  end

  assign pix_ready_o   = pix_ready_q;
  assign sram_addr_o   = addr_q;
  assign sram_dq_out_o = data_q;
  assign sram_dq_oe_o  = dq_oe_q;
  assign sram_we_n_o   = we_n_q;
  assign sram_oe_n_o   = oe_n_q;
  assign disp_en_o     = disp_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_sof_o     = err_sof_q;

  a_we_needs_oe: assert property (@(posedge clk108) disable iff (!rst)
    !sram_we_n_o |-> sram_dq_oe_o);

  a_we_bus_stable: assert property (@(posedge clk108) disable iff (!rst)
    !sram_we_n_o |-> ($stable(sram_addr_o) && $stable(sram_dq_out_o)));

  a_addr_in_frame: assert property (@(posedge clk108) disable iff (!rst)
    sram_addr_o <= LAST_ADDR);

  a_disp_hand_off: assert property (@(posedge clk108) disable iff (!rst)
    disp_en_o == sram_oe_n_o |-> 1'b0);

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench: the stimulus queues the expected SRAM writes, and a negedge monitor checks each we_n strobe against that queue.
module tb_sram_frame_writer;

  localparam int FW = 16;
  localparam int AW = 20;

  logic          clk108 = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [15:0]   pix_data = '0;
  logic          pix_ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe, sram_we_n, sram_oe_n, disp_en, busy, done, err_sof;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int t0;
  logic [35:0] exp_q[$];

  sram_frame_writer #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk108       (clk108),
    .rst          (rst),
    .start_i      (start),
    .pix_valid_i  (pix_valid),
    .pix_sof_i    (pix_sof),
    .pix_data_i   (pix_data),
    .pix_ready_o  (pix_ready),
    .sram_addr_o  (sram_addr),
    .sram_dq_out_o(sram_dq_out),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_we_n_o  (sram_we_n),
    .sram_oe_n_o  (sram_oe_n),
    .disp_en_o    (disp_en),
    .busy_o       (busy),
    .done_o       (done),
    .err_sof_o    (err_sof)
  );

  always #5 clk108 = ~clk108;
  always @(posedge clk108) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each low cycle of we_n must match the next queued write.
  always @(negedge clk108) begin : monitor
    logic [35:0] e;
    if (rst && !sram_we_n) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", sram_addr, sram_dq_out);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(sram_addr), 32'(e[35:16]));
        chk("wr_data", 32'(sram_dq_out), 32'(e[15:0]));
        chk("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
      end
    end
  end

  // Present one word and hold it until it is accepted. The handshake happens on the posedge after pix_ready is seen.
  task automatic send(input logic [15:0] d, input logic sof, input logic wr, input logic [19:0] a);
    int n = 0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    while (!pix_ready && n < 40) begin
      @(negedge clk108);
      n++;
    end
    if (!pix_ready) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout: pix_ready 0 after %0d cycles, expected 1", n);
    end else begin
      hs_cyc = cyc;
      if (wr) exp_q.push_back({a, d});
    end
    @(negedge clk108);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Call this right after send() returns for the last word, which is in the SETUP cycle.
  task automatic expect_done();
    repeat (2) @(negedge clk108);
    chk("done_early", 32'(done), 32'd0);
    @(negedge clk108);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_disp_en", 32'(disp_en), 32'd1);
    chk("done_addr", 32'(sram_addr), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("done_oe_n", 32'(sram_oe_n), 32'd0);
    @(negedge clk108);
    chk("done_single", 32'(done), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk108);
    start = 1'b0;
    chk("arm_disp_en", 32'(disp_en), 32'd0);
    chk("arm_ready", 32'(pix_ready), 32'd1);
    chk("arm_oe_n", 32'(sram_oe_n), 32'd1);
    chk("arm_busy", 32'(busy), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk108);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk108);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
    end
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_disp_en", 32'(disp_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_sof", 32'(err_sof), 32'd0);

    // Frame 1: three words without sof are dropped, then a full frame with random gaps.
    pulse_start();
    send(16'h1111, 1'b0, 1'b0, 20'd0);
    send(16'h2222, 1'b0, 1'b0, 20'd0);
    send(16'h3333, 1'b0, 1'b0, 20'd0);
    chk("discard_no_oe", 32'(sram_dq_oe), 32'd0);
    send(16'hA5C3, 1'b1, 1'b1, 20'd0);
    t0 = hs_cyc;
    send(16'h1234, 1'b0, 1'b1, 20'd1);
    chk("word_spacing", 32'(hs_cyc - t0), 32'd4);
    chk("no_err_sof", 32'(err_sof), 32'd0);
    chk("setup_ready", 32'(pix_ready), 32'd0);
    for (int i = 2; i < FW; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk108);
      send(16'h0100 + 16'(i), 1'b0, 1'b1, 20'(i));
    end
    expect_done();
    chk("f1_idle_disp_en", 32'(disp_en), 32'd1);

    // Frame 2: a sof arrives on word 7, so the frame restarts at address 0. start is held for the re-arm check.
    pulse_start();
    send(16'h7000, 1'b1, 1'b1, 20'd0);
    for (int i = 1; i < 7; i++) send(16'h7000 + 16'(i), 1'b0, 1'b1, 20'(i));
    send(16'h7777, 1'b1, 1'b1, 20'd0);
    chk("err_sof_pulse", 32'(err_sof), 32'd1);
    chk("err_sof_addr", 32'(sram_addr), 32'd0);
    @(negedge clk108);
    chk("err_sof_single", 32'(err_sof), 32'd0);
    start = 1'b1;
    for (int i = 1; i < FW; i++) send(16'h7800 + 16'(i), 1'b0, 1'b1, 20'(i));
    expect_done();
    chk("rearm_disp_en", 32'(disp_en), 32'd0);
    chk("rearm_ready", 32'(pix_ready), 32'd1);
    start = 1'b0;

    // Frame 3 follows the immediate re-arm.
    for (int i = 0; i < FW; i++) send(16'h9000 + 16'(i), (i == 0), 1'b1, 20'(i));
    expect_done();
    chk("f3_disp_en", 32'(disp_en), 32'd1);

    // Assert reset in the middle of a write strobe.
    pulse_start();
    send(16'hBEEF, 1'b1, 1'b1, 20'd0);
    @(negedge clk108);
    chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_mid_disp_en", 32'(disp_en), 32'd1);
    chk("rst_mid_ready", 32'(pix_ready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_addr", 32'(sram_addr), 32'd0);
    @(negedge clk108);
    rst = 1'b1;
    repeat (3) @(negedge clk108);
    chk("post_rst_ready", 32'(pix_ready), 32'd0);
    chk("post_rst_disp_en", 32'(disp_en), 32'd1);
    chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_frame_writer.md
# sram_frame_writer

Write-side companion to the VGA frame-buffer display path. It accepts a 16-bit pixel stream ({R[15:8], B[7:0]}) over a valid/ready handshake and writes one full frame into the external 16-bit asynchronous SRAM at sequential word addresses, starting at 0. While it owns the SRAM, it holds the display path off through `disp_en`. Top level muxes `sram_addr` between this block and the display reader on `disp_en`.

## Interface
Parameters:
- FRAME_WORDS, 1048576: words per frame (1024x1024).
- ADDR_W, 20: SRAM word-address width.

Ports:
- clk108  in  1  pixel/system clock, 108 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; arms capture of the next frame when idle or done.
- pix_valid  in  1  pixel word valid.
- pix_sof  in  1  start-of-frame marker, qualified by pix_valid.
- pix_data  in  16  pixel word, R in [15:8], B in [7:0].
- pix_ready  out  1  block accepts a word this cycle.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  tri-state enable for the SRAM data bus.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- disp_en  out  1  1 = display reader owns the SRAM and runs; 0 = writer owns it (display counters held at 0).
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse after the last word is written.
- err_sof  out  1  one-cycle pulse on an unexpected mid-frame SOF.

## Operation
- All outputs are registered.
- Reset values:
  - State IDLE; sram_addr 0; sram_dq_out 0; sram_dq_oe 0.
  - sram_we_n 1; sram_oe_n 0; pix_ready 0.
  - disp_en 1; busy 0; done 0; err_sof 0.
- States:
  - **IDLE**: disp_en=1, sram_oe_n=0. start=1 -> ARM.
  - **ARM**: disp_en=0, sram_oe_n=1, busy=1, pix_ready=1.
    - Words with pix_sof=0 are consumed and discarded.
    - valid&sof: latch pix_data, sram_addr<=0 -> SETUP.
  - **ACCEPT**: pix_ready=1.
    - valid&!sof: latch pix_data, sram_addr<=sram_addr+1 -> SETUP.
    - valid&sof: err_sof pulse, sram_addr<=0, latch word as word 0 -> SETUP (frame restarts).
  - **SETUP**: sram_dq_oe=1, sram_we_n=1; address and data stable.
  - **WRITE**: sram_we_n=0; sram_dq_oe, address and data held.
  - **HOLD**: sram_we_n=1; data still driven.
    - sram_addr==FRAME_WORDS-1: -> DONE.
    - Otherwise -> ACCEPT.
  - **DONE**:
    - On entry: done pulse for 1 cycle; sram_dq_oe=0; sram_addr<=0; disp_en=1; sram_oe_n=0; busy=0.
    - start=1 -> ARM (re-capture). Otherwise stay in DONE.
- start while busy is ignored.
- Address never exceeds FRAME_WORDS-1; there is no wrap inside a frame.
- sram_we_n is never low while sram_dq_oe=0.
- sram_we_n is never low in the same cycle that address or data change.
- disp_en falls in the same cycle that sram_oe_n rises (IDLE/DONE -> ARM).
- Reset asserted mid-write: all outputs return to reset values asynchronously; sram_we_n goes high immediately. A partially written frame is not resumed.

## Timing
- Handshake at cycle N (pix_valid & pix_ready):
  - N+1: SETUP, pix_ready=0.
  - N+2: sram_we_n=0.
  - N+3: sram_we_n=1.
  - N+4: pix_ready=1 again.
- Sustained throughput: 1 word / 4 clocks. Each phase is 9.26 ns (at 108 MHz), which meets 10 ns-class SRAM setup, pulse-width and hold.
- Last word: HOLD at cycle M; done=1, disp_en=1 at M+1.
- start sampled in IDLE at cycle S: disp_en=0, pix_ready=1 at S+1.

## Test plan
- Reset, then idle 10 cycles -> every output at its reset value; sram_we_n stays 1.
- start, 3 words without sof, then sof word 0xA5C3, then 0x1234 -> first two stored at addr 0/1 with one we_n low pulse each; discarded words cause no we_n activity; 4-cycle spacing per word.
- FRAME_WORDS=16, full 16-word frame with random valid gaps -> addresses 0..15 written in order; done pulses once one cycle after HOLD of addr 15; disp_en returns to 1; sram_addr=0.
- sof asserted on word 7 of a frame -> err_sof pulse; that word is written at addr 0; the frame then completes 16 words from there.
- Reset deasserted-then-asserted during WRITE -> sram_we_n=1 and sram_dq_oe=0 in the same cycle; state IDLE; disp_en=1.
- start held high through DONE -> immediate re-arm: disp_en=0 one cycle after DONE; second frame is written from addr 0.
